// File: rtl/mcp3008_sampler_pkg.sv
// Shared definitions for the MCP3008 sampler: FSM states, the 24-slot
// conversion frame layout, ADC word width and the DIN command encoder.
package mcp3008_sampler_pkg;

  localparam int ADC_W = 10;

  // Slot layout of one conversion (each slot = one AD_CLK period).
  localparam logic [4:0] SLOT_START      = 5'd0;
  localparam logic [4:0] SLOT_DATA_FIRST = 5'd7;
  localparam logic [4:0] SLOT_DATA_LAST  = 5'd16;
  localparam logic [4:0] SLOT_LAST       = 5'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Command bit for a slot: start, single-ended, then channel MSB first.
  function automatic logic din_bit(input logic [4:0] slot, input logic [2:0] ch);
    case (slot)
      5'd0:    return 1'b1;
      5'd1:    return 1'b1;
      5'd2:    return ch[2];
      5'd3:    return ch[1];
      5'd4:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcp3008_sampler_ram.sv
// sample_pingpong_ram: two banks of SAMPLES x ADC_W words.
// One write port, one registered read port (block RAM style).
// Ports: clk; we/wr_bank/wr_addr/wr_data write side;
//        rd_bank/rd_addr in, rd_data out one clk later.
module sample_pingpong_ram
  import mcp3008_sampler_pkg::*;
#(
  parameter int SAMPLES = 128
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic                       wr_bank,
  input  logic [$clog2(SAMPLES)-1:0] wr_addr,
  input  logic [ADC_W-1:0]           wr_data,
  input  logic                       rd_bank,
  input  logic [$clog2(SAMPLES)-1:0] rd_addr,
  output logic [ADC_W-1:0]           rd_data
);

  logic [ADC_W-1:0] mem [2*SAMPLES];

  // No reset: buffer contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/mcp3008_sampler.sv
// mcp3008_sampler: free-running single-ended MCP3008 sampler writing a
// ping-pong frame buffer.
// Ports: clk, rst_n (sync, active-low), enable;
//        ADC side AD_CLK/CS/DIN out, DOUT in;
//        sample_valid/sample_data per-sample result;
//        rd_addr/rd_data read of the completed bank, frame_ready/frame_bank.
module mcp3008_sampler
  import mcp3008_sampler_pkg::*;
#(
  parameter int CLK_DIV = 37,
  parameter int CHANNEL = 0,
  parameter int SAMPLES = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       AD_CLK,
  output logic                       CS,
  output logic                       DIN,
  input  logic                       DOUT,
  output logic                       sample_valid,
  output logic [ADC_W-1:0]           sample_data,
  input  logic [$clog2(SAMPLES)-1:0] rd_addr,
  output logic [ADC_W-1:0]           rd_data,
  output logic                       frame_ready,
  output logic                       frame_bank
);

  localparam int AW = $clog2(SAMPLES);
  localparam int DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [2:0]    CH      = 3'(CHANNEL);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV);
  localparam logic [AW-1:0] PTR_MAX = '1;

  logic [DW-1:0]    div_cnt;
  logic             strobe, rise, fall;
  state_t           state, state_nx;
  logic [4:0]       slot, slot_nx;
  logic             cs_nx, din_nx, done;
  logic [ADC_W-1:0] shreg;
  logic [AW-1:0]    wr_ptr;
  logic             wr_bank;

  // AD_CLK edges are known one clk ahead: strobe plus current level.
  assign strobe = (div_cnt == DIV_MAX);
  assign rise   = strobe & ~AD_CLK;
  assign fall   = strobe &  AD_CLK;

  // Slot sequencing happens only on AD_CLK falls, so CS/DIN change while
  // AD_CLK goes low and are stable for the ADC's rising-edge sample.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    cs_nx    = CS;
    din_nx   = DIN;
    done     = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (enable) begin
            state_nx = CONVERT;
            slot_nx  = SLOT_START;
            cs_nx    = 1'b0;
            din_nx   = din_bit(SLOT_START, CH);
          end
        end
        CONVERT: begin
          slot_nx = slot + 5'd1;
          din_nx  = din_bit(slot + 5'd1, CH);
          if (slot == SLOT_DATA_LAST) begin
            state_nx = GAP;
            cs_nx    = 1'b1;
            done     = 1'b1;
          end
        end
        GAP: begin
          if (slot == SLOT_LAST) begin
            slot_nx = SLOT_START;
            if (enable) begin
              state_nx = CONVERT;
              cs_nx    = 1'b0;
              din_nx   = din_bit(SLOT_START, CH);
            end else begin
              state_nx = IDLE;
              din_nx   = 1'b0;
            end
          end else begin
            slot_nx = slot + 5'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= '0;
      CS    <= 1'b1;
      DIN   <= 1'b0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      CS    <= cs_nx;
      DIN   <= din_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      AD_CLK       <= 1'b0;
      shreg        <= '0;
      sample_valid <= 1'b0;
      frame_ready  <= 1'b0;
      sample_data  <= '0;
      frame_bank   <= 1'b1;
      wr_bank      <= 1'b0;
      wr_ptr       <= '0;
    end else begin
      div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      if (strobe) AD_CLK <= ~AD_CLK;
      // Slot 6 is the null bit; only B9..B0 are shifted in.
      if (rise && state == CONVERT && slot >= SLOT_DATA_FIRST && slot <= SLOT_DATA_LAST)
        shreg <= {shreg[ADC_W-2:0], DOUT};
      sample_valid <= done;
      frame_ready  <= done && (wr_ptr == PTR_MAX);
      if (done) begin
        sample_data <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
        if (wr_ptr == PTR_MAX) begin
          wr_bank    <= ~wr_bank;
          frame_bank <= wr_bank;
        end
      end
    end
  end

  // Reads always come from frame_bank, writes from wr_bank; they differ.
  sample_pingpong_ram #(.SAMPLES(SAMPLES)) u_ram (
    .clk     (clk),
    .we      (done),
    .wr_bank (wr_bank),
    .wr_addr (wr_ptr),
    .wr_data (shreg),
    .rd_bank (frame_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_mcp3008_sampler.sv
// Directed bench for mcp3008_sampler with a behavioural MCP3008 model.
module tb_mcp3008_sampler;

  localparam int CLK_DIV = 1;
  localparam int CHANNEL = 5;
  localparam int SAMPLES = 128;
  localparam int CONV_CLK = 24 * 2 * (CLK_DIV + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       AD_CLK, CS, DIN;
  logic       DOUT = 1'b0;
  logic       sample_valid, frame_ready, frame_bank;
  logic [9:0] sample_data, rd_data;
  logic [6:0] rd_addr = '0;

  int total = 0;
  int bad = 0;

  mcp3008_sampler #(.CLK_DIV(CLK_DIV), .CHANNEL(CHANNEL), .SAMPLES(SAMPLES)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .AD_CLK(AD_CLK), .CS(CS), .DIN(DIN), .DOUT(DOUT),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_bank(frame_bank)
  );

  always #5 clk = ~clk;

  // ---------------- ADC model ----------------
  logic       ramp_mode = 1'b0;
  logic [9:0] fixed_val = 10'h2A5;
  logic [9:0] adc_val = '0;
  int         ramp_n = 0;
  int         rcnt = 0;
  int         cs_falls = 0;
  logic [4:0] din_cap = '0;

  // A wake with CS low and AD_CLK low is a CS fall; CS low and AD_CLK high
  // is an AD_CLK rise inside the conversion.
  always @(negedge CS or posedge AD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      ramp_n = 0;
      rcnt   = 0;
    end else if (CS === 1'b0 && AD_CLK === 1'b0) begin
      cs_falls = cs_falls + 1;
      rcnt     = 0;
      adc_val  = ramp_mode ? ramp_n[9:0] : fixed_val;
      ramp_n   = ramp_n + 1;
    end else if (CS === 1'b0 && AD_CLK === 1'b1) begin
      if (rcnt < 5) din_cap[rcnt] = DIN;
      rcnt = rcnt + 1;
      // present the bit the ADC will sample at the next rise
      DOUT = (rcnt >= 7 && rcnt <= 16) ? adc_val[16 - rcnt] : 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  int cyc = 0;
  int sv_cnt = 0, sv_last = 0, sv_prev = 0;
  int fr_cnt = 0, fr_at_sv = 0;
  logic fr_with_sv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_cnt  = sv_cnt + 1;
      sv_prev = sv_last;
      sv_last = cyc;
    end
    if (frame_ready === 1'b1) begin
      fr_cnt     = fr_cnt + 1;
      fr_with_sv = sample_valid;
      fr_at_sv   = sv_cnt;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_sv(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sv_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cs_fall(input int budget, output bit ok);
    int f0;
    f0 = cs_falls;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs_falls != f0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rcnt(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rcnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int cs_bad, ck_bad;
    cs_bad = 0; ck_bad = 0;
    rst_n = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (CS !== 1'b1) cs_bad++;
      if (AD_CLK !== 1'b0) ck_bad++;
    end
    total++; if (cs_bad != 0) begin bad++; $display("FAIL reset_cs: bad cycles %0d want 0", cs_bad); end
    total++; if (ck_bad != 0) begin bad++; $display("FAIL reset_adclk: bad cycles %0d want 0", ck_bad); end
    total++; if (DIN !== 1'b0) begin bad++; $display("FAIL reset_din: got %b want 0", DIN); end
    total++; if (sample_valid !== 1'b0 || frame_ready !== 1'b0) begin
      bad++; $display("FAIL reset_pulses: sv=%b fr=%b want 0 0", sample_valid, frame_ready); end
    total++; if (sample_data !== 10'd0) begin bad++; $display("FAIL reset_data: got %h want 000", sample_data); end
    total++; if (frame_bank !== 1'b1) begin bad++; $display("FAIL reset_frame_bank: got %b want 1", frame_bank); end
    rst_n = 1'b1;
    // divider: rise strobe at 2nd edge, fall strobe (CS low) at 4th edge
    repeat (3) @(posedge clk);
    #1;
    total++; if (CS !== 1'b1) begin bad++; $display("FAIL first_cs_early: got %b want 1 after 3 edges", CS); end
    @(posedge clk);
    #1;
    total++; if (CS !== 1'b0) begin bad++; $display("FAIL first_cs_fall: got %b want 0 after 4 edges", CS); end
    total++; if (AD_CLK !== 1'b0) begin bad++; $display("FAIL first_fall_adclk: got %b want 0", AD_CLK); end
  endtask

  task automatic test_basic;
    bit ok;
    int s0, cf0;
    int exp_din [5] = '{1, 1, 1, 0, 1};
    s0 = sv_cnt; cf0 = cs_falls;
    wait_sv(s0 + 1, 4 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_sv_timeout: got none want 1 sample"); end
    total++; if (sample_data !== 10'h2A5) begin bad++; $display("FAIL basic_data: got %h want 2a5", sample_data); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (din_cap[i] !== exp_din[i][0]) begin
        bad++; $display("FAIL basic_din_slot%0d: got %b want %0d", i, din_cap[i], exp_din[i]); end
    end
    @(negedge clk);
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL basic_sv_pulse: got %b want 0 next clk", sample_valid); end
    wait_sv(s0 + 2, 4 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_sv2_timeout: got none want 2nd sample"); end
    total++; if (sv_last - sv_prev != CONV_CLK) begin
      bad++; $display("FAIL basic_throughput: got %0d clks want %0d", sv_last - sv_prev, CONV_CLK); end
    total++; if (cs_falls - cf0 != 1 || sv_cnt - s0 != 2) begin
      bad++; $display("FAIL basic_one_per_conv: cs falls %0d samples %0d want 1 2", cs_falls - cf0, sv_cnt - s0); end
  endtask

  task automatic test_enable_drop;
    bit ok;
    int s0, cf;
    fixed_val = 10'h155;
    wait_cs_fall(3 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_cs_timeout: got no CS fall want one"); end
    wait_rcnt(11, CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_slot_timeout: got rcnt %0d want 11", rcnt); end
    enable = 1'b0;
    s0 = sv_cnt;
    wait_sv(s0 + 1, 2 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_sv_timeout: got none want 1 sample"); end
    total++; if (sample_data !== 10'h155) begin bad++; $display("FAIL drop_data: got %h want 155", sample_data); end
    total++; if (CS !== 1'b1) begin bad++; $display("FAIL drop_cs_slot17: got %b want 1", CS); end
    cf = cs_falls;
    repeat (300) @(negedge clk);
    total++; if (cs_falls != cf || CS !== 1'b1) begin
      bad++; $display("FAIL drop_idle: cs falls %0d CS=%b want 0 and 1", cs_falls - cf, CS); end
    total++; if (sv_cnt != s0 + 1) begin bad++; $display("FAIL drop_sv_count: got %0d want %0d", sv_cnt - s0, 1); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int s0;
    enable = 1'b1;
    wait_cs_fall(CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_cs_timeout: got no CS fall want one"); end
    wait_rcnt(13, CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_slot_timeout: got rcnt %0d want 13", rcnt); end
    s0 = sv_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (CS !== 1'b1) begin bad++; $display("FAIL mid_cs_high: got %b want 1", CS); end
    @(negedge clk);
    rst_n = 1'b1;
    ramp_mode = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (sv_cnt != s0) begin bad++; $display("FAIL mid_no_sample: got %0d samples want 0", sv_cnt - s0); end
  endtask

  // Runs straight after the mid-conversion reset: wr_ptr must restart at 0
  // for the frame boundary to land on the 128th sample.
  task automatic test_frames;
    bit ok;
    int base, fb, errs;
    base = sv_cnt; fb = fr_cnt;
    wait_sv(base + 128, 130 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame1_timeout: got %0d samples want 128", sv_cnt - base); end
    total++; if (fr_cnt - fb != 1 || fr_with_sv !== 1'b1 || fr_at_sv != base + 128) begin
      bad++; $display("FAIL frame1_pulse: frames %0d with_sv %b at %0d want 1 1 128", fr_cnt - fb, fr_with_sv, fr_at_sv - base); end
    total++; if (frame_bank !== 1'b0) begin bad++; $display("FAIL frame1_bank: got %b want 0", frame_bank); end
    errs = 0;
    for (int i = 0; i < 128; i++) begin
      rd_addr = 7'(i);
      @(posedge clk);
      #1;
      total++;
      if (rd_data !== 10'(i)) begin
        bad++; errs++;
        if (errs < 4) $display("FAIL frame1_read[%0d]: got %0d want %0d", i, rd_data, i);
      end
    end
    // bank 0 untouched while bank 1 fills
    wait_sv(base + 200, 80 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_frame_timeout: got %0d want 200", sv_cnt - base); end
    for (int i = 0; i < 128; i += 9) begin
      rd_addr = 7'(i);
      @(posedge clk);
      #1;
      total++;
      if (rd_data !== 10'(i)) begin bad++; $display("FAIL bank0_hold[%0d]: got %0d want %0d", i, rd_data, i); end
    end
    wait_sv(base + 256, 70 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame2_timeout: got %0d want 256", sv_cnt - base); end
    total++; if (fr_cnt - fb != 2 || fr_at_sv != base + 256) begin
      bad++; $display("FAIL frame2_pulse: frames %0d at %0d want 2 256", fr_cnt - fb, fr_at_sv - base); end
    total++; if (frame_bank !== 1'b1) begin bad++; $display("FAIL frame2_bank: got %b want 1", frame_bank); end
    for (int i = 0; i < 128; i += 5) begin
      rd_addr = 7'(i);
      @(posedge clk);
      #1;
      total++;
      if (rd_data !== 10'(128 + i)) begin bad++; $display("FAIL frame2_read[%0d]: got %0d want %0d", i, rd_data, 128 + i); end
    end
    wait_sv(base + 384, 140 * CONV_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame3_timeout: got %0d want 384", sv_cnt - base); end
    total++; if (frame_bank !== 1'b0 || fr_cnt - fb != 3) begin
      bad++; $display("FAIL frame3_bank: bank %b frames %0d want 0 3", frame_bank, fr_cnt - fb); end
    for (int i = 0; i < 128; i += 7) begin
      rd_addr = 7'(i);
      @(posedge clk);
      #1;
      total++;
      if (rd_data !== 10'(256 + i)) begin bad++; $display("FAIL frame3_read[%0d]: got %0d want %0d", i, rd_data, 256 + i); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_enable_drop;
    test_reset_mid;
    test_frames;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
